regfile_writeback_queue: RTL and testbench

Write-side companion of the 32-entry register set. It collects results from the ALU and load/store paths through valid/ready handshakes and buffers them in a DEPTH-entry FIFO. It serialises them onto the register set's single write port (write/wnum/wdata), one write per cycle, in arrival order. It also exports a pending-write mask and a two-port bypass lookup, so decode can forward values that are not yet committed.

---
 rtl/regfile_writeback_queue.sv | 186 ++++++++++++++++++
 tb/tb_regfile_writeback_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// Write-back queue for the 32-entry register set: merges ALU and load results,
// serialises them onto the single write port and exposes pending-write bypass/busy.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              write,
    output logic [ADDR_W-1:0] wnum,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] q_rnum1,
    input  logic [ADDR_W-1:0] q_rnum2,
    output logic              hit1,
    output logic [DATA_W-1:0] hit_data1,
    output logic              hit2,
    output logic [DATA_W-1:0] hit_data2,
    output logic [31:0]       busy,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ent_rd_q   [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              write_q;
    logic [ADDR_W-1:0] wnum_q;
    logic [DATA_W-1:0] wdata_q;

    logic              mem_push;
    logic              alu_push;
    logic              pop;
    logic [PTR_W-1:0]  alu_slot;

    // Readiness looks only at the occupancy at cycle start; the load path wins the last slot.
    always_comb begin
        mem_ready = (count_q < CNT_W'(DEPTH));
        alu_ready = (count_q < CNT_W'(DEPTH - 1)) ||
                    ((count_q == CNT_W'(DEPTH - 1)) && !mem_valid);
    end

    // Results for r0 finish the handshake but are never stored.
    assign mem_push = mem_valid && mem_ready && (mem_rd != '0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
    assign pop      = (count_q != '0);
    assign alu_slot = wr_ptr_q + PTR_W'(mem_push);

    always_comb begin
        count_d  = count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(mem_push) + PTR_W'(alu_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage slots; the mem entry takes the first free slot, the alu entry the one after.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    ent_rd_q[gi]   <= '0;
                    ent_data_q[gi] <= '0;
                end else if (mem_push && (wr_ptr_q == PTR_W'(gi))) begin
                    ent_rd_q[gi]   <= mem_rd;
                    ent_data_q[gi] <= mem_data;
                end else if (alu_push && (alu_slot == PTR_W'(gi))) begin
                    ent_rd_q[gi]   <= alu_rd;
                    ent_data_q[gi] <= alu_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            wnum_q  <= '0;
            wdata_q <= '0;
        end else begin
            write_q <= pop;
            if (pop) begin
                wnum_q  <= ent_rd_q[rd_ptr_q];
                wdata_q <= ent_data_q[rd_ptr_q];
            end
        end
    end

    assign write = write_q;
    assign wnum  = wnum_q;
    assign wdata = wdata_q;
    assign empty = (count_q == '0) && !write_q;

    // Entries re-ordered by age: index 0 is the oldest queued entry.
    logic              age_vld  [DEPTH];
    logic [PTR_W-1:0]  age_idx  [DEPTH];
    logic [ADDR_W-1:0] age_rd   [DEPTH];
    logic [DATA_W-1:0] age_data [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_idx[gi]  = rd_ptr_q + PTR_W'(gi);
            assign age_vld[gi]  = (CNT_W'(gi) < count_q);
            assign age_rd[gi]   = ent_rd_q[age_idx[gi]];
            assign age_data[gi] = ent_data_q[age_idx[gi]];
        end
    endgenerate

    logic [31:0] busy_vec;

    always_comb begin
        busy_vec = '0;
        if (write_q) begin
            busy_vec[wnum_q] = 1'b1;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (age_vld[k]) begin
                busy_vec[age_rd[k]] = 1'b1;
            end
        end
        busy_vec[0] = 1'b0;
    end

    assign busy = busy_vec;

    logic [ADDR_W-1:0] lk_rnum [2];
    logic              lk_hit  [2];
    logic [DATA_W-1:0] lk_data [2];

    assign lk_rnum[0] = q_rnum1;
    assign lk_rnum[1] = q_rnum2;

    // Scan oldest to youngest so the youngest match overrides earlier ones.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
            always_comb begin
                lk_hit[gi]  = 1'b0;
                lk_data[gi] = '0;
                if (write_q && (wnum_q == lk_rnum[gi])) begin
                    lk_hit[gi]  = 1'b1;
                    lk_data[gi] = wdata_q;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if (age_vld[k] && (age_rd[k] == lk_rnum[gi])) begin
                        lk_hit[gi]  = 1'b1;
                        lk_data[gi] = age_data[k];
                    end
                end
                if (lk_rnum[gi] == '0) begin
                    lk_hit[gi]  = 1'b0;
                    lk_data[gi] = '0;
                end
            end
        end
    endgenerate

    assign hit1      = lk_hit[0];
    assign hit_data1 = lk_data[0];
    assign hit2      = lk_hit[1];
    assign hit_data2 = lk_data[1];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: a reference queue tracks accepted
// results and is drained against the write port, bypass and busy outputs.
module tb_regfile_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid, alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid, mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              write;
    logic [ADDR_W-1:0] wnum;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] q_rnum1, q_rnum2;
    logic              hit1, hit2;
    logic [DATA_W-1:0] hit_data1, hit_data2;
    logic [31:0]       busy;
    logic              empty;

    always #5 clk = ~clk;

    regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .write(write), .wnum(wnum), .wdata(wdata),
        .q_rnum1(q_rnum1), .q_rnum2(q_rnum2),
        .hit1(hit1), .hit_data1(hit_data1), .hit2(hit2), .hit_data2(hit_data2),
        .busy(busy), .empty(empty)
    );

    int checks = 0;
    int errors = 0;

    entry_t            model_q[$];
    logic              out_v;
    logic [ADDR_W-1:0] out_rd;
    logic [DATA_W-1:0] out_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] exp_lookup(input logic [ADDR_W-1:0] r);
        if (r == 0) return 33'd0;
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].rd == r) return {1'b1, model_q[i].data};
        end
        if (out_v && out_rd == r) return {1'b1, out_data};
        return 33'd0;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b = '0;
        if (out_v) b[out_rd] = 1'b1;
        foreach (model_q[i]) b[model_q[i].rd] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic check_outputs(input string tag);
        logic [32:0] l1, l2;
        l1 = exp_lookup(q_rnum1);
        l2 = exp_lookup(q_rnum2);
        chk({tag, ".write"},     32'(write),     32'(out_v));
        chk({tag, ".wnum"},      32'(wnum),      32'(out_rd));
        chk({tag, ".wdata"},     wdata,          out_data);
        chk({tag, ".empty"},     32'(empty),     32'(model_q.size() == 0 && !out_v));
        chk({tag, ".busy"},      busy,           exp_busy());
        chk({tag, ".hit1"},      32'(hit1),      32'(l1[32]));
        chk({tag, ".hit_data1"}, hit_data1,      l1[31:0]);
        chk({tag, ".hit2"},      32'(hit2),      32'(l2[32]));
        chk({tag, ".hit_data2"}, hit_data2,      l2[31:0]);
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic step(input string tag,
                        input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                        input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md);
        int     n;
        logic   exp_mr, exp_ar, pop;
        entry_t head;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #1;
        n      = model_q.size();
        exp_mr = (n < DEPTH);
        exp_ar = (n < DEPTH - 1) || (n == DEPTH - 1 && !mv);
        chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(exp_mr));
        chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(exp_ar));
        pop  = (n > 0);
        head = '0;
        if (pop) head = model_q.pop_front();
        if (mv && exp_mr && mrd != 0) model_q.push_back({mrd, md});
        if (av && exp_ar && ard != 0) model_q.push_back({ard, ad});
        out_v = pop;
        if (pop) begin
            out_rd   = head.rd;
            out_data = head.data;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        $display("%s: alu=%0b/%0b mem=%0b/%0b write=%0b wnum=%0d wdata=%h queued=%0d",
                 tag, av, exp_ar, mv, exp_mr, write, wnum, wdata, model_q.size());
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        out_v    = 1'b0;
        out_rd   = '0;
        out_data = '0;
        check_outputs(tag);
        $display("%s: reset write=%0b empty=%0b busy=%h", tag, write, empty, busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        q_rnum1 = '0; q_rnum2 = '0;
        out_v = 1'b0; out_rd = '0; out_data = '0;
        @(posedge clk);
        do_reset("reset");

        // 1: single ALU push, one-cycle latency
        q_rnum1 = 5; q_rnum2 = 6;
        step("t1_push", 1'b1, 5'd5, 32'h0000_00AA, 1'b0, '0, '0);
        idle("t1_wr");
        chk("t1_direct_write", 32'(write), 32'd1);
        chk("t1_direct_wdata", wdata, 32'h0000_00AA);
        chk("t1_direct_busy5", 32'(busy[5]), 32'd1);
        idle("t1_done");
        chk("t1_direct_empty", 32'(empty), 32'd1);

        // 2: simultaneous pushes to the same register, mem entry first
        q_rnum1 = 3; q_rnum2 = 5;
        step("t2_push", 1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 32'h11);
        idle("t2_wr1");
        chk("t2_direct_wdata1", wdata, 32'h11);
        chk("t2_direct_hit_data1", hit_data1, 32'h22);
        idle("t2_wr2");
        chk("t2_direct_wdata2", wdata, 32'h22);
        idle("t2_done");

        // 3: sustained pushes on both sources
        q_rnum1 = 7; q_rnum2 = 9;
        for (int i = 0; i < 6; i++)
            step($sformatf("t3_push%0d", i), 1'b1, 5'(7 + i % 3), 32'h300 + i,
                 1'b1, 5'd9, 32'h400 + i);
        for (int i = 0; i < 5; i++) idle($sformatf("t3_drain%0d", i));

        // 4: writes to r0 are dropped
        q_rnum1 = 0; q_rnum2 = 0;
        step("t4_r0", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
        idle("t4_chk");
        chk("t4_direct_write", 32'(write), 32'd0);

        // 5: reset discards queued entries
        q_rnum1 = 10; q_rnum2 = 11;
        step("t5_fill0", 1'b1, 5'd10, 32'h500, 1'b1, 5'd11, 32'h501);
        step("t5_fill1", 1'b1, 5'd10, 32'h502, 1'b1, 5'd11, 32'h503);
        do_reset("t5_rst");
        chk("t5_direct_busy", busy, 32'd0);
        for (int i = 0; i < 3; i++) idle($sformatf("t5_after%0d", i));

        // 6: both sources held valid for 8 cycles
        q_rnum1 = 12; q_rnum2 = 13;
        for (int i = 0; i < 8; i++)
            step($sformatf("t6_push%0d", i), 1'b1, 5'd12, 32'h600 + i, 1'b1, 5'd13, 32'h700 + i);
        for (int i = 0; i < 5; i++) idle($sformatf("t6_drain%0d", i));

        // Mixed traffic over a small register range
        for (int i = 0; i < 24; i++) begin
            q_rnum1 = 5'($urandom_range(0, 7));
            q_rnum2 = 5'($urandom_range(0, 7));
            step($sformatf("mix%0d", i),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < 5; i++) idle($sformatf("mix_drain%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
